mul_rr_arbiter: RTL and testbench

// Round-robin arbiter sharing one pipelined multiplier instance among N_REQ requesters in
// the mel filter stage (bin power x filter weight products). Accepts operand pairs over

---
 rtl/mul_rr_arbiter.sv | 65 ++++++
 tb/tb_mul_rr_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mul_rr_arbiter.sv
// mul_rr_arbiter: round-robin sharing of one pipelined multiplier with tagged product return
module mul_rr_arbiter #(
  parameter int N_REQ   = 4,
  parameter int A_WIDTH = 16,
  parameter int B_WIDTH = 16,
  parameter int P_WIDTH = 16,
  parameter int MUL_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*A_WIDTH-1:0]   req_a,
  input  logic [N_REQ*B_WIDTH-1:0]   req_b,
  output logic [N_REQ-1:0]           req_ready,
  output logic [A_WIDTH-1:0]         mul_a,
  output logic [B_WIDTH-1:0]         mul_b,
  input  logic [P_WIDTH-1:0]         mul_p,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [P_WIDTH-1:0]         rsp_p,
  output logic                       busy
);
  localparam int PW = $clog2(N_REQ);
  logic [PW-1:0]    rr_ptr, gidx;
  logic             hit, acc;
  logic [N_REQ-1:0] tag [MUL_LAT+1];
  function automatic logic [PW-1:0] wrap(input int s);
    return PW'(s >= N_REQ ? s - N_REQ : s);
  endfunction
  // first valid requester at or after rr_ptr wins; nothing is granted during reset
  always_comb begin
    req_ready = '0;
    gidx = '0;
    hit = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!rst && !hit && req_valid[wrap(int'(rr_ptr) + k)]) begin
        req_ready[wrap(int'(rr_ptr) + k)] = 1'b1;
        gidx = wrap(int'(rr_ptr) + k);
        hit = 1'b1;
      end
    end
  end
  assign acc = hit;
  // operand register, pointer advance and tag shift; idle cycles push zeros
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      mul_a <= '0;
      mul_b <= '0;
      for (int k = 0; k <= MUL_LAT; k++) tag[k] <= '0;
    end else begin
      if (acc) rr_ptr <= (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
      mul_a <= acc ? req_a[gidx*A_WIDTH +: A_WIDTH] : '0;
      mul_b <= acc ? req_b[gidx*B_WIDTH +: B_WIDTH] : '0;
      tag[0] <= req_ready;
      for (int k = 1; k <= MUL_LAT; k++) tag[k] <= tag[k-1];
    end
  end
  // any tag stage occupied means an operation is still in flight
  always_comb begin
    busy = 1'b0;
    for (int k = 0; k <= MUL_LAT; k++) busy = busy | (|tag[k]);
  end
  assign rsp_valid = tag[MUL_LAT];
  assign rsp_p = mul_p;
endmodule

// File: tb/tb_mul_rr_arbiter.sv
// tb_mul_rr_arbiter: table vectors, corner sequences and random traffic against an accept-log model
module tb_mul_rr_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_a, req_b;
  logic [3:0]  req_ready, rsp_valid;
  logic [15:0] mul_a, mul_b, mul_p, rsp_p;
  logic        busy;
  logic [15:0] s1 = '0, s2 = '0;

  mul_rr_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_p(rsp_p), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mm(input logic [15:0] a, input logic [15:0] b);
    return 16'((32'(a) * 32'(b)) >> 8);
  endfunction

  always @(posedge clk) begin
    s1 <= mm(mul_a, mul_b);
    s2 <= s1;
  end
  assign mul_p = s2;

  typedef struct { int c; int req; logic [15:0] a; logic [15:0] b; } acc_t;
  typedef struct { logic [3:0] v; logic [3:0] rdy; logic [3:0] rsp; logic bsy; } vec_t;

  acc_t        log_q[$];
  vec_t        tbl[21];
  int          cyc = 0, ptr = 0, n_tests = 0, n_fail = 0, g;
  logic [15:0] cur_a[4], cur_b[4], pa[4], pb[4];
  logic [3:0]  pv = '0, pr = '0, pend = '0;
  logic [3:0]  s_ready, s_rsp;
  logic [15:0] s_mul_a, s_rsp_p;
  logic        s_busy;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", n, cyc, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] v, output int gr);
    logic [15:0] ea, eb, ep;
    logic [3:0]  er;
    logic        ebusy;
    for (int i = 0; i < 4; i++)
      if (pv[i] && !pr[i]) begin
        chk("hold_valid", 32'(v[i]), 32'(1));
        chk("hold_data", {cur_a[i], cur_b[i]}, {pa[i], pb[i]});
      end
    rst = r;
    req_valid = v;
    for (int i = 0; i < 4; i++) begin
      req_a[i*16 +: 16] = cur_a[i];
      req_b[i*16 +: 16] = cur_b[i];
      pa[i] = cur_a[i];
      pb[i] = cur_b[i];
    end
    pv = v;
    #1;
    gr = -1;
    if (!r)
      for (int k = 0; k < 4; k++)
        if (gr < 0 && v[(ptr + k) % 4]) gr = (ptr + k) % 4;
    ea = '0; eb = '0; ep = '0; er = '0; ebusy = 1'b0;
    foreach (log_q[j]) begin
      if (log_q[j].c == cyc - 1) begin ea = log_q[j].a; eb = log_q[j].b; end
      if (log_q[j].c == cyc - 3) begin er = 4'(1 << log_q[j].req); ep = mm(log_q[j].a, log_q[j].b); end
      if (log_q[j].c >= cyc - 3 && log_q[j].c < cyc) ebusy = 1'b1;
    end
    chk("req_ready", 32'(req_ready), gr >= 0 ? 32'(1) << gr : 32'(0));
    chk("mul_a", 32'(mul_a), 32'(ea));
    chk("mul_b", 32'(mul_b), 32'(eb));
    chk("rsp_valid", 32'(rsp_valid), 32'(er));
    if (er != 0) chk("rsp_p", 32'(rsp_p), 32'(ep));
    chk("busy", 32'(busy), 32'(ebusy));
    s_ready = req_ready; s_rsp = rsp_valid; s_busy = busy; s_mul_a = mul_a; s_rsp_p = rsp_p;
    pr = req_ready;
    if (r) begin
      log_q.delete();
      ptr = 0;
    end else if (gr >= 0) begin
      log_q.push_back('{cyc, gr, cur_a[gr], cur_b[gr]});
      ptr = (gr + 1) % 4;
      cur_a[gr] = 16'($urandom);
      cur_b[gr] = 16'($urandom);
    end
    if (log_q.size() > 4) void'(log_q.pop_front());
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input logic r, input logic [3:0] add);
    int gg;
    pend = pend | add;
    step(r, pend, gg);
    if (gg >= 0) pend[gg] = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{4'hF, 4'h1, 4'h0, 1'b0};
    tbl[1]  = '{4'hF, 4'h2, 4'h0, 1'b1};
    tbl[2]  = '{4'hF, 4'h4, 4'h0, 1'b1};
    tbl[3]  = '{4'hF, 4'h8, 4'h1, 1'b1};
    tbl[4]  = '{4'hF, 4'h1, 4'h2, 1'b1};
    tbl[5]  = '{4'hF, 4'h2, 4'h4, 1'b1};
    tbl[6]  = '{4'hF, 4'h4, 4'h8, 1'b1};
    tbl[7]  = '{4'hF, 4'h8, 4'h1, 1'b1};
    tbl[8]  = '{4'h7, 4'h1, 4'h2, 1'b1};
    tbl[9]  = '{4'h6, 4'h2, 4'h4, 1'b1};
    tbl[10] = '{4'h4, 4'h4, 4'h8, 1'b1};
    tbl[11] = '{4'h1, 4'h1, 4'h1, 1'b1};
    tbl[12] = '{4'h2, 4'h2, 4'h2, 1'b1};
    tbl[13] = '{4'hA, 4'h8, 4'h4, 1'b1};
    tbl[14] = '{4'hA, 4'h2, 4'h1, 1'b1};
    tbl[15] = '{4'hA, 4'h8, 4'h2, 1'b1};
    tbl[16] = '{4'h2, 4'h2, 4'h8, 1'b1};
    tbl[17] = '{4'h0, 4'h0, 4'h2, 1'b1};
    tbl[18] = '{4'h0, 4'h0, 4'h8, 1'b1};
    tbl[19] = '{4'h0, 4'h0, 4'h2, 1'b1};
    tbl[20] = '{4'h0, 4'h0, 4'h0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      cur_a[i] = 16'($urandom);
      cur_b[i] = 16'($urandom);
    end
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    run(1'b1, 4'h0);
    chk("reset_ready", 32'(s_ready), 32'(0));
    chk("reset_busy", 32'(s_busy), 32'(0));
    for (int i = 0; i < 21; i++) begin
      step(1'b0, tbl[i].v, g);
      chk("tbl_ready", 32'(s_ready), 32'(tbl[i].rdy));
      chk("tbl_rsp", 32'(s_rsp), 32'(tbl[i].rsp));
      chk("tbl_busy", 32'(s_busy), 32'(tbl[i].bsy));
    end
    run(1'b1, 4'h0);
    cur_a[0] = 16'h0100;
    cur_b[0] = 16'h0200;
    run(1'b0, 4'h1);
    chk("t1_ready", 32'(s_ready), 32'h1);
    run(1'b0, 4'h0);
    chk("t1_mul_a", 32'(s_mul_a), 32'h0100);
    chk("t1_rsp_early", 32'(s_rsp), 32'h0);
    run(1'b0, 4'h0);
    chk("t1_rsp_early", 32'(s_rsp), 32'h0);
    run(1'b0, 4'h0);
    chk("t1_rsp", 32'(s_rsp), 32'h1);
    chk("t1_rsp_p", 32'(s_rsp_p), 32'h0200);
    run(1'b0, 4'h0);
    run(1'b1, 4'h0);
    run(1'b0, 4'hF);
    run(1'b0, 4'h0);
    run(1'b1, 4'h0);
    chk("t4_ready_in_rst", 32'(s_ready), 32'h0);
    run(1'b0, 4'hF);
    chk("t4_first_grant", 32'(s_ready), 32'h1);
    chk("t4_no_stale", 32'(s_rsp), 32'h0);
    run(1'b0, 4'h0);
    chk("t4_no_stale", 32'(s_rsp), 32'h0);
    run(1'b0, 4'h0);
    chk("t4_no_stale", 32'(s_rsp), 32'h0);
    repeat (8) run(1'b0, 4'h0);
    run(1'b1, 4'h0);
    for (int k = 0; k < 9; k++) begin
      run(1'b0, k < 5 ? 4'h4 : 4'h0);
      chk("t5_ready", 32'(s_ready), k < 5 ? 32'h4 : 32'h0);
      chk("t5_rsp", 32'(s_rsp), (k >= 3 && k < 8) ? 32'h4 : 32'h0);
      chk("t6_busy", 32'(s_busy), (k >= 1 && k <= 7) ? 32'h1 : 32'h0);
    end
    run(1'b1, 4'h0);
    for (int k = 0; k < 400; k++)
      run($urandom_range(0, 63) == 0, 4'($urandom_range(0, 15)));
    repeat (10) run(1'b0, 4'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
